sfx_scheduler: RTL and testbench
================================

# sfx_scheduler

Sound-effect scheduler for the ducking-duck game: accepts one-cycle event pulses from the game core (jump, point, hit), queues them, arbitrates by fixed priority, and sequences the single mono audio amplifier (ampPWM/ampSD) through tone and silence intervals. It sits between the core's event outputs and the board's audio pins, running directly on board_clk (100 MHz).

## Interface
- HP_JUMP, 56818 — jump tone half-period in clocks (880 Hz)
- HP_POINT, 37922 — point tone half-period in clocks (~1318 Hz)
- HP_HIT, 227272 — hit tone half-period in clocks (220 Hz)
- DUR_JUMP, 8000000 — jump tone length in clocks (80 ms)
- DUR_POINT, 12000000 — point tone length in clocks (120 ms)
- DUR_HIT, 40000000 — hit tone length in clocks (400 ms)
- GAP, 1000000 — silence between consecutive tones in clocks (10 ms)
- HPW, 18 — half-period counter width; DURW, 26 — duration/gap counter width
- board_clk  in  1  system clock, 100 MHz
- Reset  in  1  reset, asynchronous, active-high
- req_jump  in  1  single-cycle request pulse
- req_point  in  1  single-cycle request pulse
- req_hit  in  1  single-cycle request pulse
- mute  in  1  level; silences and flushes while high
- ampPWM  out  1  registered square-wave audio
- ampSD  out  1  registered amplifier enable (1 = on)
- busy  out  1  state != IDLE
- active  out  2  playing source: 0 none, 1 jump, 2 point, 3 hit

## Operation
- Pending flags pend[3:1], one per source; request pulse sets flag; grant clears it; set wins over clear in the same cycle (re-request during grant stays queued). Multiple pulses while pending collapse to one.
- Priority: hit > point > jump.
- FSM states IDLE, TONE, GAP.
  - IDLE: if any pend, grant highest; load half-period counter with HP-1, duration counter with DUR-1; active=source; ampSD=1; ampPWM=0; go TONE. Else stay, ampSD=0, active=0.
  - TONE: half-period counter decrements; at 0 toggle ampPWM, reload HP-1. Duration counter decrements; at 0 → GAP, load GAP-1, ampPWM=0, ampSD=0, active=0.
  - GAP: count down; at 0 → IDLE.
- mute high: pend cleared and new requests ignored; next edge forces IDLE, ampPWM=0, ampSD=0, active=0.
- Reset: state IDLE, pend=0, counters 0, ampPWM=0, ampSD=0, active=0, busy=0.

## Timing
- Request sampled at edge E0 → pend set; edge E1 → TONE, ampSD=1, active valid. Latency 2 edges from pulse to ampSD.
- First ampPWM rise HP clocks after TONE entry; period exactly 2·HP clocks, 50% duty.
- TONE lasts exactly DUR clocks; GAP exactly GAP clocks; IDLE lasts ≥1 clock between GAP and next TONE.
- Back-to-back tones: end of tone N to start of tone N+1 = GAP+1 clocks.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- SFX_PREEMPT_EN defined: in TONE, a pending source of strictly higher priority than active aborts the current tone on the next edge and loads the new tone directly (no GAP); aborted source is not re-queued. ampPWM restarts at 0.
- Undefined: current tone always runs to completion; higher-priority requests wait in pend.

## Structure
- Package sfx_pkg: state enum (IDLE, TONE, GAP), source codes (SRC_NONE..SRC_HIT), default HP/DUR/GAP constants.
- Sub-module sfx_tone_gen: half-period counter + toggle flip-flop with load/enable inputs; scheduler owns FSM, pend flags, duration/gap counter, arbitration.
- Tests override HP/DUR/GAP with small values (e.g. HP 4/3/8, DUR 40/60/100, GAP 10).

## Test plan
- Reset mid-TONE (small params): assert Reset → ampPWM=0, ampSD=0, active=0, busy=0 immediately; pend empty after release.
- Single req_jump: ampSD high 2 edges later, active=1, ampPWM period 8 clocks for 40 clocks, then 10 idle clocks, busy falls.
- req_jump, req_point, req_hit same cycle: play order hit(3), point(2), jump(1), each separated by GAP+1 clocks.
- req_jump repeated 5× during its own tone and once in its grant cycle: exactly one extra jump tone follows.
- With SFX_PREEMPT_EN: req_jump, then req_hit 15 clocks into tone → active=3 next edge+1, jump not replayed; without macro → jump finishes full 40 clocks first.
- mute raised mid-tone with point pending → next edge IDLE, outputs 0, pending flushed; requests during mute produce no tone after mute falls.

Source files
------------

// File: rtl/sfx_pkg.sv
// sfx_pkg: shared types and defaults for the sound-effect scheduler.
//   state_t  - scheduler FSM states (IDLE / TONE / GAP)
//   src_t    - sound source codes, numerically ordered by priority
//   DEF_*    - default half-period, duration and gap lengths at 100 MHz
//   pick_src - fixed-priority pick among pending sources (hit > point > jump)
package sfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Code value doubles as priority rank, so preemption is a plain compare.
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_JUMP  = 2'd1,
    SRC_POINT = 2'd2,
    SRC_HIT   = 2'd3
  } src_t;

  localparam int DEF_HP_JUMP   = 56818;
  localparam int DEF_HP_POINT  = 37922;
  localparam int DEF_HP_HIT    = 227272;
  localparam int DEF_DUR_JUMP  = 8000000;
  localparam int DEF_DUR_POINT = 12000000;
  localparam int DEF_DUR_HIT   = 40000000;
  localparam int DEF_GAP       = 1000000;
  localparam int DEF_HPW       = 18;
  localparam int DEF_DURW      = 26;

  // pend[3]=hit, pend[2]=point, pend[1]=jump
  function automatic src_t pick_src(input logic [3:1] pend);
    if (pend[3])      return SRC_HIT;
    else if (pend[2]) return SRC_POINT;
    else if (pend[1]) return SRC_JUMP;
    else              return SRC_NONE;
  endfunction

endpackage

// File: rtl/sfx_scheduler_if.sv
// sfx_scheduler_if: event/audio bundle between game core and scheduler.
//   req_jump/req_point/req_hit - single-cycle request pulses
//   mute                       - level, silences and flushes while high
//   ampPWM/ampSD               - audio square wave / amplifier enable
//   busy                       - scheduler not idle
//   active                     - source currently playing (src_t code)
// master: game core side (drives requests); slave: scheduler side.
interface sfx_scheduler_if;
  logic       req_jump;
  logic       req_point;
  logic       req_hit;
  logic       mute;
  logic       ampPWM;
  logic       ampSD;
  logic       busy;
  logic [1:0] active;

  modport master (
    output req_jump, req_point, req_hit, mute,
    input  ampPWM, ampSD, busy, active
  );

  modport slave (
    input  req_jump, req_point, req_hit, mute,
    output ampPWM, ampSD, busy, active
  );
endinterface

// File: rtl/sfx_tone_gen.sv
// sfx_tone_gen: half-period counter plus toggle flop producing a 50% square wave.
//   board_clk/Reset - clock, asynchronous active-high reset
//   clr   - force output low and counter to 0 (highest priority)
//   load  - start a new tone: latch hp_m1 as reload value, output low
//   en    - advance the counter; toggles output when it reaches 0
//   hp_m1 - half-period minus one, sampled on load
//   pwm   - registered square wave
module sfx_tone_gen
  import sfx_pkg::*;
#(
  parameter int HPW = DEF_HPW
) (
  input  logic           board_clk,
  input  logic           Reset,
  input  logic           clr,
  input  logic           load,
  input  logic           en,
  input  logic [HPW-1:0] hp_m1,
  output logic           pwm
);

  logic [HPW-1:0] cnt_q, cnt_d;
  logic [HPW-1:0] hp_q, hp_d;
  logic           pwm_q, pwm_d;

  always_comb begin
    cnt_d = cnt_q;
    hp_d  = hp_q;
    pwm_d = pwm_q;
    if (clr) begin
      cnt_d = '0;
      pwm_d = 1'b0;
    end else if (load) begin
      cnt_d = hp_m1;
      hp_d  = hp_m1;
      pwm_d = 1'b0;
    end else if (en) begin
      if (cnt_q == '0) begin
        pwm_d = ~pwm_q;
        cnt_d = hp_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      hp_q  <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hp_q  <= hp_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: queues jump/point/hit sound requests and sequences the mono
// amplifier through tone and silence intervals, highest priority first.
//   board_clk - 100 MHz clock
//   Reset     - asynchronous, active-high
//   bus       - sfx_scheduler_if.slave (requests, mute, ampPWM/ampSD/busy/active)
// Build option: define SFX_PREEMPT_EN to let a strictly higher-priority
// request abort the tone in progress (no gap; the aborted source is dropped).
// Without it every tone runs to completion and later requests wait.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int HP_JUMP   = DEF_HP_JUMP,
  parameter int HP_POINT  = DEF_HP_POINT,
  parameter int HP_HIT    = DEF_HP_HIT,
  parameter int DUR_JUMP  = DEF_DUR_JUMP,
  parameter int DUR_POINT = DEF_DUR_POINT,
  parameter int DUR_HIT   = DEF_DUR_HIT,
  parameter int GAP       = DEF_GAP,
  parameter int HPW       = DEF_HPW,
  parameter int DURW      = DEF_DURW
) (
  input logic            board_clk,
  input logic            Reset,
  sfx_scheduler_if.slave bus
);

  localparam logic [HPW-1:0]  HPM_JUMP  = HPW'(HP_JUMP - 1);
  localparam logic [HPW-1:0]  HPM_POINT = HPW'(HP_POINT - 1);
  localparam logic [HPW-1:0]  HPM_HIT   = HPW'(HP_HIT - 1);
  localparam logic [DURW-1:0] DM_JUMP   = DURW'(DUR_JUMP - 1);
  localparam logic [DURW-1:0] DM_POINT  = DURW'(DUR_POINT - 1);
  localparam logic [DURW-1:0] DM_HIT    = DURW'(DUR_HIT - 1);
  localparam logic [DURW-1:0] GAP_M1    = DURW'(GAP - 1);

  state_t          state_q, state_d;
  logic [3:1]      pend_q, pend_d;
  logic [DURW-1:0] dur_q, dur_d;
  src_t            active_q, active_d;
  logic            amp_sd_q, amp_sd_d;

  logic [3:1]      req;
  logic [3:1]      grant;
  src_t            pick;
  logic            start;
  logic [HPW-1:0]  hp_sel;
  logic [DURW-1:0] dur_sel;
  logic            tg_clr, tg_load, tg_en, tg_pwm;

  assign req  = {bus.req_hit, bus.req_point, bus.req_jump};
  assign pick = pick_src(pend_q);

  // Tone parameters and grant mask for the winning pending source.
  always_comb begin
    hp_sel  = '0;
    dur_sel = '0;
    grant   = '0;
    case (pick)
      SRC_JUMP:  begin hp_sel = HPM_JUMP;  dur_sel = DM_JUMP;  grant = 3'b001; end
      SRC_POINT: begin hp_sel = HPM_POINT; dur_sel = DM_POINT; grant = 3'b010; end
      SRC_HIT:   begin hp_sel = HPM_HIT;   dur_sel = DM_HIT;   grant = 3'b100; end
      default:   ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    dur_d    = dur_q;
    active_d = active_q;
    amp_sd_d = amp_sd_q;
    start    = 1'b0;
    tg_clr   = 1'b0;
    tg_load  = 1'b0;
    tg_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick != SRC_NONE) begin
          start = 1'b1;
        end else begin
          amp_sd_d = 1'b0;
          active_d = SRC_NONE;
        end
      end
      ST_TONE: begin
        tg_en = 1'b1;
`ifdef SFX_PREEMPT_EN
        if (pick > active_q) begin
          start = 1'b1;
        end else
`endif
        if (dur_q == '0) begin
          // Final tone clock: drop the amp and silence the wave together.
          state_d  = ST_GAP;
          dur_d    = GAP_M1;
          tg_clr   = 1'b1;
          amp_sd_d = 1'b0;
          active_d = SRC_NONE;
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (dur_q == '0) state_d = ST_IDLE;
        else             dur_d   = dur_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d  = ST_TONE;
      dur_d    = dur_sel;
      active_d = pick;
      amp_sd_d = 1'b1;
      tg_load  = 1'b1;
    end

    // A fresh pulse beats the grant so a re-request in the grant cycle stays queued.
    pend_d = (pend_q & ~(start ? grant : 3'b000)) | req;

    if (bus.mute) begin
      state_d  = ST_IDLE;
      pend_d   = '0;
      dur_d    = '0;
      active_d = SRC_NONE;
      amp_sd_d = 1'b0;
      tg_clr   = 1'b1;
      tg_load  = 1'b0;
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      dur_q    <= '0;
      active_q <= SRC_NONE;
      amp_sd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      dur_q    <= dur_d;
      active_q <= active_d;
      amp_sd_q <= amp_sd_d;
    end
  end

  sfx_tone_gen #(.HPW(HPW)) u_tone (
    .board_clk (board_clk),
    .Reset     (Reset),
    .clr       (tg_clr),
    .load      (tg_load),
    .en        (tg_en),
    .hp_m1     (hp_sel),
    .pwm       (tg_pwm)
  );

  assign bus.ampPWM = tg_pwm;
  assign bus.ampSD  = amp_sd_q;
  assign bus.active = active_q;
  assign bus.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: directed bench for sfx_scheduler with shrunken timing
// (HP 4/3/8, DUR 40/60/100, GAP 10). Inputs change and outputs are sampled
// on the falling edge; the DUT acts on rising edges.
// Honours SFX_PREEMPT_EN to select the expected preemption behaviour.
module tb_sfx_scheduler;
  localparam int HPJ = 4,  HPP = 3,  HPH = 8;
  localparam int DJ  = 40, DP  = 60, DH  = 100;
  localparam int G   = 10;

  logic board_clk;
  logic Reset;
  int   vecs = 0;
  int   errs = 0;

  sfx_scheduler_if bus();

  sfx_scheduler #(
    .HP_JUMP(HPJ), .HP_POINT(HPP), .HP_HIT(HPH),
    .DUR_JUMP(DJ), .DUR_POINT(DP), .DUR_HIT(DH),
    .GAP(G), .HPW(18), .DURW(26)
  ) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  initial begin
    board_clk = 1'b0;
    forever #5 board_clk = ~board_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  // Pulse requests for one cycle; returns at the sample point of the TONE entry edge.
  task automatic pulse(input bit j, input bit p, input bit h);
    bus.req_jump = j; bus.req_point = p; bus.req_hit = h;
    step(1);
    bus.req_jump = 0; bus.req_point = 0; bus.req_hit = 0;
    chk("lat_sd_early", bus.ampSD, 0);
    step(1);
  endtask

  // Check tone clocks k0..k1-1 (k counted from TONE entry). Wave is high in odd half-periods.
  task automatic check_tone(input logic [1:0] src, input int hp, input int k0, input int k1,
                            input bit rep);
    for (int k = k0; k < k1; k++) begin
      chk("tone_sd", bus.ampSD, 1);
      chk("tone_active", bus.active, src);
      chk("tone_busy", bus.busy, 1);
      chk("tone_pwm", bus.ampPWM, (k / hp) % 2);
      if (rep) bus.req_jump = (k > 0 && k <= 25 && k % 5 == 0);
      step(1);
    end
  endtask

  // Called at the first GAP clock; returns at the first IDLE clock.
  task automatic check_gap();
    for (int g = 0; g < G; g++) begin
      chk("gap_busy", bus.busy, 1);
      chk("gap_sd", bus.ampSD, 0);
      chk("gap_active", bus.active, 0);
      chk("gap_pwm", bus.ampPWM, 0);
      step(1);
    end
    chk("idle_busy", bus.busy, 0);
    chk("idle_sd", bus.ampSD, 0);
  endtask

  task automatic check_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      chk("quiet_busy", bus.busy, 0);
      chk("quiet_sd", bus.ampSD, 0);
      chk("quiet_active", bus.active, 0);
      step(1);
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.req_jump = 0; bus.req_point = 0; bus.req_hit = 0; bus.mute = 0;

    // Reset state
    step(2);
    chk("rst_pwm", bus.ampPWM, 0);
    chk("rst_sd", bus.ampSD, 0);
    chk("rst_active", bus.active, 0);
    chk("rst_busy", bus.busy, 0);
    Reset = 1'b0;
    step(2);
    check_quiet(2);

    // Single jump: 2-edge latency, period 8, 40 clocks, 10 gap clocks
    pulse(1, 0, 0);
    check_tone(2'd1, HPJ, 0, DJ, 0);
    check_gap();
    check_quiet(3);

    // Simultaneous requests play hit, point, jump with GAP+1 spacing
    pulse(1, 1, 1);
    check_tone(2'd3, HPH, 0, DH, 0);
    check_gap();
    step(1);
    check_tone(2'd2, HPP, 0, DP, 0);
    check_gap();
    step(1);
    check_tone(2'd1, HPJ, 0, DJ, 0);
    check_gap();
    check_quiet(3);

    // Re-requests in the grant cycle and during the tone collapse to one extra tone
    bus.req_jump = 1;
    step(1);
    chk("rep_sd_early", bus.ampSD, 0);
    step(1);
    bus.req_jump = 0;
    check_tone(2'd1, HPJ, 0, DJ, 1);
    check_gap();
    step(1);
    check_tone(2'd1, HPJ, 0, DJ, 0);
    check_gap();
    check_quiet(3);

    // Hit request 15 clocks into a jump tone
    pulse(1, 0, 0);
    check_tone(2'd1, HPJ, 0, 15, 0);
    bus.req_hit = 1;
    check_tone(2'd1, HPJ, 15, 16, 0);
    bus.req_hit = 0;
`ifdef SFX_PREEMPT_EN
    chk("pre_active_old", bus.active, 1);
    chk("pre_pwm_old", bus.ampPWM, 0);
    step(1);
    check_tone(2'd3, HPH, 0, DH, 0);
    check_gap();
    check_quiet(3);
`else
    check_tone(2'd1, HPJ, 16, DJ, 0);
    check_gap();
    step(1);
    check_tone(2'd3, HPH, 0, DH, 0);
    check_gap();
    check_quiet(3);
`endif

    // Mute mid-tone with point pending: forced idle, queue flushed, requests ignored
    pulse(0, 0, 1);
    check_tone(2'd3, HPH, 0, 10, 0);
    bus.req_point = 1;
    check_tone(2'd3, HPH, 10, 11, 0);
    bus.req_point = 0;
    bus.mute = 1;
    step(1);
    chk("mute_busy", bus.busy, 0);
    chk("mute_sd", bus.ampSD, 0);
    chk("mute_active", bus.active, 0);
    chk("mute_pwm", bus.ampPWM, 0);
    bus.req_jump = 1; bus.req_hit = 1;
    step(1);
    bus.req_jump = 0; bus.req_hit = 0;
    check_quiet(2);
    bus.mute = 0;
    step(1);
    check_quiet(5);
    // Scheduler still accepts requests after mute
    pulse(0, 1, 0);
    check_tone(2'd2, HPP, 0, 4, 0);

    // Reset mid-tone: outputs drop without waiting for a clock edge
    bus.mute = 1;
    step(1);
    bus.mute = 0;
    step(1);
    pulse(1, 0, 0);
    check_tone(2'd1, HPJ, 0, 5, 0);
    chk("pre_rst_pwm", bus.ampPWM, 1);
    bus.req_hit = 1;
    step(1);
    bus.req_hit = 0;
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_pwm", bus.ampPWM, 0);
    chk("arst_sd", bus.ampSD, 0);
    chk("arst_active", bus.active, 0);
    chk("arst_busy", bus.busy, 0);
    step(1);
    Reset = 1'b0;
    step(1);
    check_quiet(4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
